// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS symbol type, control-period codes and default disparity counter width.
package tmds_pkg;
  typedef logic [9:0] sym_t;
  localparam int CNT_W_DEF = 5;
  localparam sym_t CTRL_00 = 10'b1101010100;
  localparam sym_t CTRL_01 = 10'b0010101011;
  localparam sym_t CTRL_10 = 10'b0101010100;
  localparam sym_t CTRL_11 = 10'b1010101011;
  function automatic sym_t ctrl_sym(input logic [1:0] c);
    return c == 2'b00 ? CTRL_00 : c == 2'b01 ? CTRL_01 : c == 2'b10 ? CTRL_10 : CTRL_11;
  endfunction
endpackage

// File: rtl/tmds_popcount8.sv
// tmds_popcount8: combinational count of ones in an 8-bit word.
module tmds_popcount8 (
  input  logic [7:0] d,
  output logic [3:0] n
);
  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
  end
endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: two-stage TMDS 8b/10b channel encoder (transition minimise, then DC balance).
// Defining TMDS_DISP_MON_EN adds the disp_cnt / disp_err running-disparity monitor ports.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int   CNT_W     = CNT_W_DEF,
  parameter sym_t RESET_SYM = CTRL_00
) (
  input  logic             pix_clk,
  input  logic             rst,
  input  logic             de,
  input  logic [7:0]       data,
  input  logic             c0,
  input  logic             c1,
  output sym_t             tmds_out
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [CNT_W-1:0] disp_cnt,
  output logic             disp_err
`endif
);
  logic [7:0] dm;
  logic [3:0] n1d, n1q;
  logic xnr, de1, c0_1, c1_1, bal_z, same_sign;
  logic [8:0] qm_nx, qm;
  logic signed [CNT_W-1:0] cnt, cnt_nx, bal, two;
  sym_t sym_nx;
  // data is forced to zero in control periods so unknown pixels never reach the pipeline
  assign dm = de ? data : '0;
  tmds_popcount8 u_pc_d (.d(dm), .n(n1d));
  assign xnr = n1d > 4'd4 || (n1d == 4'd4 && !dm[0]);
  always_comb begin
    qm_nx[0] = dm[0];
    for (int i = 1; i < 8; i++) qm_nx[i] = xnr ? ~(qm_nx[i-1] ^ dm[i]) : qm_nx[i-1] ^ dm[i];
    qm_nx[8] = ~xnr;
  end
  always_ff @(posedge pix_clk or posedge rst)
    if (rst) {qm, de1, c1_1, c0_1} <= '0;
    else {qm, de1, c1_1, c0_1} <= {qm_nx, de, c1, c0};
  tmds_popcount8 u_pc_q (.d(qm[7:0]), .n(n1q));
  // bal = n1q - n0q = 2*n1q - 8, kept in counter width
  assign bal = CNT_W'({n1q, 1'b0}) - CNT_W'(8);
  assign two = qm[8] ? CNT_W'(2) : '0;
  assign bal_z = cnt == '0 || bal == '0;
  assign same_sign = (cnt > 0 && bal > 0) || (cnt < 0 && bal < 0);
  always_comb begin
    sym_nx = !de1 ? ctrl_sym({c1_1, c0_1}) :
             bal_z ? {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]} :
             {same_sign, qm[8], same_sign ? ~qm[7:0] : qm[7:0]};
    cnt_nx = !de1 ? '0 :
             bal_z ? (qm[8] ? cnt + bal : cnt - bal) :
             same_sign ? cnt + two - bal :
             cnt + bal - (CNT_W'(2) - two);
  end
  always_ff @(posedge pix_clk or posedge rst)
    if (rst) begin
      tmds_out <= RESET_SYM;
      cnt      <= '0;
    end else begin
      tmds_out <= sym_nx;
      cnt      <= cnt_nx;
    end
`ifdef TMDS_DISP_MON_EN
  assign disp_cnt = cnt;
  always_ff @(posedge pix_clk or posedge rst)
    if (rst) disp_err <= 1'b0;
    else disp_err <= disp_err | (cnt > 8) | (cnt < -8) | cnt[0];
`endif
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: directed TMDS vectors with hand-derived symbols plus a model-checked random run.
module tb_tmds_encoder;
  logic pix_clk = 1'b0;
  logic rst = 1'b1;
  logic de = 1'b0;
  logic [7:0] data = 8'h00;
  logic c0 = 1'b0, c1 = 1'b0;
  logic [9:0] tmds_out;
  int n_cmp = 0, n_bad = 0, mcnt = 0;
  logic [9:0] eq[$];
  string tq[$];
`ifdef TMDS_DISP_MON_EN
  logic [4:0] disp_cnt;
  logic disp_err;
`endif

  tmds_encoder dut (
    .pix_clk(pix_clk), .rst(rst), .de(de), .data(data), .c0(c0), .c1(c1), .tmds_out(tmds_out)
`ifdef TMDS_DISP_MON_EN
    , .disp_cnt(disp_cnt), .disp_err(disp_err)
`endif
  );

  always #5 pix_clk = ~pix_clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Applies one input vector; the symbol for the previous vector is visible after this edge.
  task automatic drv(input logic d, input logic [7:0] x, input logic [1:0] c, input logic [9:0] e, input string tag);
    de = d; data = x; {c1, c0} = c;
    eq.push_back(e); tq.push_back(tag);
    @(posedge pix_clk); #1;
    if (eq.size() > 1) chk(tq.pop_front(), tmds_out, eq.pop_front());
  endtask

  // Reference: pick inversion by sign agreement, track disparity from the emitted symbol's balance.
  function automatic logic [9:0] ref_enc(input logic d, input logic [7:0] x, input logic [1:0] c);
    logic [8:0] q;
    logic [9:0] s;
    logic inv, use_xnor;
    int n1, bal;
    if (!d) begin
      mcnt = 0;
      if (c == 2'd0) s = 10'b1101010100;
      else if (c == 2'd1) s = 10'b0010101011;
      else if (c == 2'd2) s = 10'b0101010100;
      else s = 10'b1010101011;
    end else begin
      n1 = $countones(x);
      use_xnor = n1 > 4 || (n1 == 4 && !x[0]);
      q[0] = x[0];
      for (int i = 1; i < 8; i++) q[i] = use_xnor ? (q[i-1] ~^ x[i]) : (q[i-1] ^ x[i]);
      q[8] = !use_xnor;
      bal = 2 * $countones(q[7:0]) - 8;
      if (mcnt == 0 || bal == 0) inv = !q[8];
      else inv = (mcnt > 0) == (bal > 0);
      s = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
      mcnt += 2 * $countones(s) - 10;
    end
    return s;
  endfunction

  initial begin
    data = 8'hA5; de = 1'b1; {c1, c0} = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge pix_clk); #1;
      chk("reset_hold", tmds_out, 10'b1101010100);
    end
    rst = 1'b0;
    drv(0, 8'h00, 2'b00, 10'h354, "idle_a");
    drv(0, 8'h00, 2'b00, 10'h354, "idle_b");
    drv(0, 8'h00, 2'b00, 10'h354, "ctl00");
    drv(0, 8'h00, 2'b01, 10'h0AB, "ctl01");
    drv(0, 8'h00, 2'b10, 10'h154, "ctl10");
    drv(0, 8'h00, 2'b11, 10'h2AB, "ctl11");
    drv(1, 8'h00, 2'b00, 10'h100, "zero_a");
    drv(1, 8'h00, 2'b00, 10'h3FF, "zero_b");
    drv(1, 8'h00, 2'b00, 10'h100, "zero_c");
    drv(0, 8'h00, 2'b00, 10'h354, "de_drop");
    drv(1, 8'h00, 2'b00, 10'h100, "de_rise");
    drv(0, 8'bx, 2'b01, 10'h0AB, "x_ctl");
    drv(1, 8'hFF, 2'b00, 10'h200, "ff_a");
    drv(1, 8'hFF, 2'b00, 10'h0FF, "ff_b");
    drv(1, 8'hFF, 2'b00, 10'h0FF, "ff_c");
    drv(1, 8'hFF, 2'b00, 10'h200, "ff_d");
    drv(1, 8'h00, 2'b00, 10'h100, "pre_rst");
    // mid-frame asynchronous reset discards both in-flight symbols
    #2 rst = 1'b1;
    #1 chk("async_rst", tmds_out, 10'b1101010100);
    eq.delete(); tq.delete();
    @(posedge pix_clk); #1;
    chk("rst_held", tmds_out, 10'b1101010100);
    rst = 1'b0;
    drv(1, 8'h00, 2'b00, 10'h100, "post_rst");
    chk("rst_flush", tmds_out, 10'b1101010100);
    drv(0, 8'h00, 2'b00, 10'h354, "post_rst_ctl");
    drv(0, 8'h00, 2'b00, ref_enc(0, 8'h00, 2'b00), "sync");
    for (int i = 0; i < 3000; i++) begin
      logic d;
      logic [7:0] x;
      logic [1:0] c;
      d = $urandom_range(0, 7) != 0;
      x = 8'($urandom);
      c = 2'($urandom);
      drv(d, x, c, ref_enc(d, x, c), "rand");
`ifdef TMDS_DISP_MON_EN
      chk("disp_err", {9'b0, disp_err}, 10'b0);
      chk("disp_cnt_ok", {9'b0, ($signed(disp_cnt) >= -8 && $signed(disp_cnt) <= 8 && !disp_cnt[0])}, 10'b1);
`endif
    end
    drv(0, 8'h00, 2'b00, 10'h354, "tail");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
